// File: rtl/writeback_pkg.sv
// Shared types for the register-file write-side queue.
package writeback_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Circular buffer of write-back entries: up to two pushes and one pop per cycle.
module wb_fifo
  import writeback_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [1:0]       push_n_i,
  input  wb_entry_t        push0_i,
  input  wb_entry_t        push1_i,
  input  logic             pop_i,
  output wb_entry_t        head_o,
  output logic [CNT_W-1:0] count_o,
  output wb_entry_t        entries_o [DEPTH],
  output logic [DEPTH-1:0] valid_o
);

  localparam int PTR_W = $clog2(DEPTH);

  wb_entry_t        mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W-1:0] wr_ptr1_s;
  logic [CNT_W-1:0] count_r;

  assign wr_ptr1_s = wr_ptr_r + PTR_W'(1);

  // Storage, pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else begin
      if (push_n_i != 2'd0) begin
        mem_r[wr_ptr_r] <= push0_i;
      end
      if (push_n_i == 2'd2) begin
        mem_r[wr_ptr1_s] <= push1_i;
      end
      wr_ptr_r <= wr_ptr_r + PTR_W'(push_n_i);
      rd_ptr_r <= rd_ptr_r + PTR_W'(pop_i);
      count_r  <= count_r + CNT_W'(push_n_i) - CNT_W'(pop_i);
    end
  end

  // Slot i is occupied when its distance from the read pointer is below the count.
  always_comb begin
    logic [PTR_W-1:0] off_s;
    off_s   = '0;
    valid_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off_s      = PTR_W'(i) - rd_ptr_r;
      valid_o[i] = (CNT_W'(off_s) < count_r);
    end
  end

  assign head_o    = mem_r[rd_ptr_r];
  assign count_o   = count_r;
  assign entries_o = mem_r;

endmodule

// File: rtl/writeback_queue.sv
// Register-file write front end: merges ALU and long-latency results in order
// onto the single write port and publishes a pending-write mask for hazard stalls.
module writeback_queue #(
  parameter int  DEPTH  = 4,
  parameter int  DATA_W = writeback_pkg::DATA_W,
  parameter int  ADDR_W = writeback_pkg::ADDR_W,
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              alu_valid_i,
  input  logic [ADDR_W-1:0] alu_addr_i,
  input  logic [DATA_W-1:0] alu_data_i,
  output logic              alu_ready_o,
  input  logic              lu_valid_i,
  input  logic [ADDR_W-1:0] lu_addr_i,
  input  logic [DATA_W-1:0] lu_data_i,
  output logic              lu_ready_o,
  output logic              RegWrite_o,
  output logic [ADDR_W-1:0] RDaddr_o,
  output logic [DATA_W-1:0] RDdata_o,
  output logic [31:0]       busy_mask_o,
  output logic [CNT_W-1:0]  count_o
);
  import writeback_pkg::*;

  wb_entry_t         alu_ent_s;
  wb_entry_t         lu_ent_s;
  wb_entry_t         head_s;
  wb_entry_t         push0_s;
  wb_entry_t         push1_s;
  wb_entry_t         out_s;
  wb_entry_t         entries_s [DEPTH];
  logic [DEPTH-1:0]  valid_s;
  logic [CNT_W-1:0]  count_s;
  logic [1:0]        push_n_s;
  logic              pop_s;
  logic              fifo_pop_s;
  logic              ready_s;
  logic              alu_take_s;
  logic              lu_take_s;
  logic              reg_write_r;
  logic [ADDR_W-1:0] rd_addr_r;
  logic [DATA_W-1:0] rd_data_r;
  logic [31:0]       mask_s;

  // Worst case two accepts and one pop from DEPTH-2 still fits.
  assign ready_s    = (count_s <= CNT_W'(DEPTH - 2));
  assign alu_take_s = alu_valid_i && ready_s && (alu_addr_i != '0);
  assign lu_take_s  = lu_valid_i  && ready_s && (lu_addr_i  != '0);

  assign alu_ent_s.addr = alu_addr_i;
  assign alu_ent_s.data = alu_data_i;
  assign lu_ent_s.addr  = lu_addr_i;
  assign lu_ent_s.data  = lu_data_i;

  // Route the oldest result to the port; an empty queue lets the first new result bypass.
  always_comb begin
    push_n_s   = 2'd0;
    push0_s    = alu_ent_s;
    push1_s    = lu_ent_s;
    pop_s      = 1'b0;
    fifo_pop_s = 1'b0;
    out_s      = head_s;
    if (count_s != '0) begin
      pop_s      = 1'b1;
      fifo_pop_s = 1'b1;
      push_n_s   = {1'b0, alu_take_s} + {1'b0, lu_take_s};
      push0_s    = alu_take_s ? alu_ent_s : lu_ent_s;
    end else if (alu_take_s) begin
      pop_s    = 1'b1;
      out_s    = alu_ent_s;
      push_n_s = {1'b0, lu_take_s};
      push0_s  = lu_ent_s;
    end else if (lu_take_s) begin
      pop_s = 1'b1;
      out_s = lu_ent_s;
    end else begin
      pop_s = 1'b0;
    end
  end

  wb_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .push_n_i  (push_n_s),
    .push0_i   (push0_s),
    .push1_i   (push1_s),
    .pop_i     (fifo_pop_s),
    .head_o    (head_s),
    .count_o   (count_s),
    .entries_o (entries_s),
    .valid_o   (valid_s)
  );

  // Write-port registers; address and data hold their last value while idle.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      reg_write_r <= 1'b0;
      rd_addr_r   <= '0;
      rd_data_r   <= '0;
    end else if (pop_s) begin
      reg_write_r <= 1'b1;
      rd_addr_r   <= out_s.addr;
      rd_data_r   <= out_s.data;
    end else begin
      reg_write_r <= 1'b0;
    end
  end

  // Pending-write mask over buffered entries and the write in flight.
  always_comb begin
    mask_s = '0;
    if (reg_write_r) begin
      mask_s[rd_addr_r] = 1'b1;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_s[i]) begin
        mask_s[entries_s[i].addr] = 1'b1;
      end
    end
    mask_s[0] = 1'b0;
  end

  assign alu_ready_o = ready_s;
  assign lu_ready_o  = ready_s;
  assign RegWrite_o  = reg_write_r;
  assign RDaddr_o    = rd_addr_r;
  assign RDdata_o    = rd_data_r;
  assign busy_mask_o = mask_s;
  assign count_o     = count_s;

endmodule

// File: tb/tb_writeback_queue.sv
// Directed bench for writeback_queue with hand-computed expectations.
module tb_writeback_queue;

  logic        clk_i;
  logic        rst_i;
  logic        alu_valid_i;
  logic [4:0]  alu_addr_i;
  logic [31:0] alu_data_i;
  logic        alu_ready_o;
  logic        lu_valid_i;
  logic [4:0]  lu_addr_i;
  logic [31:0] lu_data_i;
  logic        lu_ready_o;
  logic        RegWrite_o;
  logic [4:0]  RDaddr_o;
  logic [31:0] RDdata_o;
  logic [31:0] busy_mask_o;
  logic [2:0]  count_o;

  int checks;
  int errors;

  writeback_queue #(.DEPTH(4), .DATA_W(32), .ADDR_W(5)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .alu_valid_i (alu_valid_i),
    .alu_addr_i  (alu_addr_i),
    .alu_data_i  (alu_data_i),
    .alu_ready_o (alu_ready_o),
    .lu_valid_i  (lu_valid_i),
    .lu_addr_i   (lu_addr_i),
    .lu_data_i   (lu_data_i),
    .lu_ready_o  (lu_ready_o),
    .RegWrite_o  (RegWrite_o),
    .RDaddr_o    (RDaddr_o),
    .RDdata_o    (RDdata_o),
    .busy_mask_o (busy_mask_o),
    .count_o     (count_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid_i = 1'b0;
    alu_addr_i  = 5'd0;
    alu_data_i  = 32'd0;
    lu_valid_i  = 1'b0;
    lu_addr_i   = 5'd0;
    lu_data_i   = 32'd0;
  endtask

  initial begin
    int exp_cnt [9];
    int exp_rdy [9];
    int ai;
    int li;
    int wi;
    logic acc;
    logic [4:0]  ea;
    logic [31:0] ed;
    exp_cnt = '{1, 2, 3, 2, 3, 2, 1, 0, 0};
    exp_rdy = '{1, 1, 0, 1, 0, 1, 1, 1, 1};
    checks = 0;
    errors = 0;
    rst_i  = 1'b0;
    idle_inputs();
    #12;
    chk("rst_count", 32'(count_o), 32'd0);
    chk("rst_regwrite", 32'(RegWrite_o), 32'd0);
    chk("rst_addr", 32'(RDaddr_o), 32'd0);
    chk("rst_data", RDdata_o, 32'd0);
    chk("rst_mask", busy_mask_o, 32'd0);
    chk("rst_alu_ready", 32'(alu_ready_o), 32'd1);
    chk("rst_lu_ready", 32'(lu_ready_o), 32'd1);
    rst_i = 1'b1;

    // single ALU write to r5
    alu_valid_i = 1'b1; alu_addr_i = 5'd5; alu_data_i = 32'h11;
    tick();
    idle_inputs();
    chk("r5_we", 32'(RegWrite_o), 32'd1);
    chk("r5_addr", 32'(RDaddr_o), 32'd5);
    chk("r5_data", RDdata_o, 32'h11);
    chk("r5_mask", busy_mask_o, 32'h20);
    chk("r5_count", 32'(count_o), 32'd0);
    tick();
    chk("r5_we_off", 32'(RegWrite_o), 32'd0);
    chk("r5_mask_off", busy_mask_o, 32'd0);
    chk("r5_addr_hold", 32'(RDaddr_o), 32'd5);
    chk("r5_data_hold", RDdata_o, 32'h11);

    // simultaneous ALU r3 and LU r4
    alu_valid_i = 1'b1; alu_addr_i = 5'd3; alu_data_i = 32'hA;
    lu_valid_i  = 1'b1; lu_addr_i  = 5'd4; lu_data_i  = 32'hB;
    tick();
    idle_inputs();
    chk("dual_we0", 32'(RegWrite_o), 32'd1);
    chk("dual_addr0", 32'(RDaddr_o), 32'd3);
    chk("dual_data0", RDdata_o, 32'hA);
    chk("dual_mask0", busy_mask_o, 32'h18);
    chk("dual_count0", 32'(count_o), 32'd1);
    tick();
    chk("dual_we1", 32'(RegWrite_o), 32'd1);
    chk("dual_addr1", 32'(RDaddr_o), 32'd4);
    chk("dual_data1", RDdata_o, 32'hB);
    chk("dual_mask1", busy_mask_o, 32'h10);
    chk("dual_count1", 32'(count_o), 32'd0);
    tick();
    chk("dual_we_off", 32'(RegWrite_o), 32'd0);
    chk("dual_mask_off", busy_mask_o, 32'd0);

    // LU write to r0 is swallowed
    lu_valid_i = 1'b1; lu_addr_i = 5'd0; lu_data_i = 32'hFF;
    chk("r0_ready", 32'(lu_ready_o), 32'd1);
    tick();
    idle_inputs();
    chk("r0_we", 32'(RegWrite_o), 32'd0);
    chk("r0_mask", busy_mask_o, 32'd0);
    chk("r0_count", 32'(count_o), 32'd0);
    chk("r0_addr_hold", 32'(RDaddr_o), 32'd4);

    // back-to-back writes to r7
    alu_valid_i = 1'b1; alu_addr_i = 5'd7; alu_data_i = 32'd1;
    tick();
    chk("r7a_we", 32'(RegWrite_o), 32'd1);
    chk("r7a_data", RDdata_o, 32'd1);
    chk("r7a_mask", busy_mask_o, 32'h80);
    alu_data_i = 32'd2;
    tick();
    idle_inputs();
    chk("r7b_we", 32'(RegWrite_o), 32'd1);
    chk("r7b_addr", 32'(RDaddr_o), 32'd7);
    chk("r7b_data", RDdata_o, 32'd2);
    chk("r7b_mask", busy_mask_o, 32'h80);
    tick();
    chk("r7_we_off", 32'(RegWrite_o), 32'd0);
    chk("r7_mask_off", busy_mask_o, 32'd0);
    chk("r7_final", RDdata_o, 32'd2);

    // saturating burst: four ALU and four LU results offered continuously
    ai = 0; li = 0; wi = 0;
    for (int c = 0; c < 9; c++) begin
      alu_valid_i = (ai < 4);
      alu_addr_i  = 5'(2 * ai + 1);
      alu_data_i  = 32'(32'h100 + 2 * ai);
      lu_valid_i  = (li < 4);
      lu_addr_i   = 5'(2 * li + 2);
      lu_data_i   = 32'(32'h101 + 2 * li);
      acc = alu_ready_o;
      tick();
      if (acc && ai < 4) ai++;
      if (acc && li < 4) li++;
      chk("burst_count", 32'(count_o), 32'(exp_cnt[c]));
      chk("burst_ready", 32'(alu_ready_o), 32'(exp_rdy[c]));
      if (c == 0) chk("burst_mask0", busy_mask_o, 32'h6);
      if (c == 2) chk("burst_mask2", busy_mask_o, 32'h78);
      if (c < 8) begin
        ea = 5'(wi + 1);
        ed = 32'(32'h100 + wi);
        chk("burst_we", 32'(RegWrite_o), 32'd1);
        chk("burst_addr", 32'(RDaddr_o), 32'(ea));
        chk("burst_data", RDdata_o, ed);
        wi++;
      end else begin
        chk("burst_we_end", 32'(RegWrite_o), 32'd0);
      end
    end
    idle_inputs();

    // reset while three entries are buffered
    for (int c = 0; c < 3; c++) begin
      alu_valid_i = 1'b1; alu_addr_i = 5'(10 + 2 * c); alu_data_i = 32'(c);
      lu_valid_i  = 1'b1; lu_addr_i  = 5'(11 + 2 * c); lu_data_i  = 32'(c + 8);
      tick();
    end
    idle_inputs();
    chk("pre_rst_count", 32'(count_o), 32'd3);
    #2;
    rst_i = 1'b0;
    #1;
    chk("mid_rst_count", 32'(count_o), 32'd0);
    chk("mid_rst_we", 32'(RegWrite_o), 32'd0);
    chk("mid_rst_mask", busy_mask_o, 32'd0);
    chk("mid_rst_ready", 32'(alu_ready_o & lu_ready_o), 32'd1);
    #2;
    rst_i = 1'b1;
    tick();
    chk("post_rst_we", 32'(RegWrite_o), 32'd0);
    chk("post_rst_count", 32'(count_o), 32'd0);
    chk("post_rst_mask", busy_mask_o, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
